// File: rtl/ccff_stream_loader.sv
// Streams DATA_W-bit configuration words MSB-first onto a CHAIN_LEN-bit ccff chain,
// one bit per prog_clk edge, with a one-word holding register to absorb source jitter.
module ccff_stream_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 34
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SHIFT, S_DONE, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift_reg, shift_reg_nxt;
    logic [DATA_W-1:0] hold_reg, hold_reg_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic [WW-1:0]     word_cnt, word_cnt_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic              head_q, head_nxt;
    logic              fire;

    assign cfg_ready = (state == S_FILL) || ((state == S_SHIFT) && !hold_valid);
    assign fire      = cfg_valid && cfg_ready;
    assign ccff_head = head_q;
    assign busy      = (state == S_FILL) || (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

    always_comb begin
        state_nxt      = state;
        shift_reg_nxt  = shift_reg;
        hold_reg_nxt   = hold_reg;
        hold_valid_nxt = hold_valid;
        word_cnt_nxt   = word_cnt;
        bit_cnt_nxt    = bit_cnt;
        head_nxt       = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt      = S_FILL;
                    shift_reg_nxt  = '0;
                    hold_reg_nxt   = '0;
                    hold_valid_nxt = 1'b0;
                    word_cnt_nxt   = '0;
                    bit_cnt_nxt    = '0;
                end
            end
            S_FILL: begin
                if (fire) begin
                    state_nxt     = S_SHIFT;
                    shift_reg_nxt = cfg_data;
                    word_cnt_nxt  = WW'(DATA_W);
                end
            end
            S_SHIFT: begin
                if (bit_cnt == BW'(CHAIN_LEN)) begin
                    // chain full: leftover word bits and any held word are dropped
                    state_nxt      = S_DONE;
                    shift_reg_nxt  = '0;
                    hold_valid_nxt = 1'b0;
                    word_cnt_nxt   = '0;
                end else if (word_cnt != '0) begin
                    head_nxt      = shift_reg[DATA_W-1];
                    shift_reg_nxt = shift_reg << 1;
                    word_cnt_nxt  = word_cnt - WW'(1);
                    bit_cnt_nxt   = bit_cnt + BW'(1);
                    if (fire) begin
                        hold_reg_nxt   = cfg_data;
                        hold_valid_nxt = 1'b1;
                    end
                end else if (hold_valid) begin
                    // word boundary: first bit of the held word goes out on this edge
                    head_nxt       = hold_reg[DATA_W-1];
                    shift_reg_nxt  = hold_reg << 1;
                    word_cnt_nxt   = WW'(DATA_W - 1);
                    bit_cnt_nxt    = bit_cnt + BW'(1);
                    hold_valid_nxt = fire;
                    if (fire) hold_reg_nxt = cfg_data;
                end else begin
                    state_nxt     = S_ERR;
                    shift_reg_nxt = '0;
                    word_cnt_nxt  = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort) begin
            state_nxt      = S_IDLE;
            head_nxt       = 1'b0;
            hold_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            head_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_reg_nxt;
            hold_reg   <= hold_reg_nxt;
            hold_valid <= hold_valid_nxt;
            word_cnt   <= word_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            head_q     <= head_nxt;
        end
    end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: queue-based bitstream model compared every cycle,
// a modelled chain checked on completion, and literal timing/content checks.
module tb_ccff_stream_loader;

    localparam int DATA_W    = 8;
    localparam int CHAIN_LEN = 34;
    localparam int M_IDLE = 0, M_FILL = 1, M_SHIFT = 2, M_DONE = 3, M_ERR = 4;

    logic              prog_clk = 1'b0;
    logic              prog_reset, start, abort, cfg_valid;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_ready, ccff_head, busy, done, error;

    ccff_stream_loader #(.DATA_W(DATA_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .busy(busy), .done(done), .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    int                m_mode = M_IDLE;
    bit                m_head = 0;
    int                m_cnt  = 0;
    bit                m_done_edge = 0;
    bit                q_bits[$];
    logic [DATA_W-1:0] m_hold[$];
    bit                acc[$];
    logic [DATA_W-1:0] src[$];
    int                gate_pct = 100;
    logic [CHAIN_LEN-1:0] tb_chain = '0;
    logic [CHAIN_LEN-1:0] last_chain = '0;

    function automatic bit m_ready();
        return (m_mode == M_FILL) || (m_mode == M_SHIFT && m_hold.size() == 0);
    endfunction

    // the downstream chain samples ccff_head on every edge
    always @(posedge prog_clk) tb_chain <= {tb_chain[CHAIN_LEN-2:0], ccff_head};

    always @(posedge prog_clk) begin : model
        bit fire;
        logic [DATA_W-1:0] w, hw;
        fire = cfg_valid && m_ready();
        w = cfg_data;
        if (fire && src.size() > 0) void'(src.pop_front());
        m_done_edge = 0;
        if (prog_reset || abort) begin
            m_mode = M_IDLE; m_head = 0; q_bits.delete(); m_hold.delete();
        end else begin
            case (m_mode)
                M_FILL: begin
                    m_head = 0;
                    if (fire) begin
                        for (int i = DATA_W-1; i >= 0; i--) begin q_bits.push_back(w[i]); acc.push_back(w[i]); end
                        m_mode = M_SHIFT;
                    end
                end
                M_SHIFT: begin
                    if (m_cnt == CHAIN_LEN) begin
                        m_mode = M_DONE; m_head = 0; m_done_edge = 1;
                        q_bits.delete(); m_hold.delete();
                    end else begin
                        if (q_bits.size() == 0 && m_hold.size() != 0) begin
                            hw = m_hold.pop_front();
                            for (int i = DATA_W-1; i >= 0; i--) q_bits.push_back(hw[i]);
                        end
                        if (q_bits.size() == 0) begin
                            m_mode = M_ERR; m_head = 0; m_hold.delete();
                        end else begin
                            m_head = q_bits.pop_front();
                            m_cnt++;
                            if (fire) begin
                                m_hold.push_back(w);
                                for (int i = DATA_W-1; i >= 0; i--) acc.push_back(w[i]);
                            end
                        end
                    end
                end
                default: begin
                    m_head = 0;
                    if (start) begin
                        m_mode = M_FILL; m_cnt = 0;
                        acc.delete(); q_bits.delete(); m_hold.delete();
                    end
                end
            endcase
        end
    end

    always @(negedge prog_clk) begin : compare
        logic [4:0] act, exp;
        logic [CHAIN_LEN-1:0] exp_chain;
        if (chk_en) begin
            exp = {m_head, m_ready(), (m_mode == M_FILL || m_mode == M_SHIFT),
                   (m_mode == M_DONE), (m_mode == M_ERR)};
            act = {ccff_head, cfg_ready, busy, done, error};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t {head,ready,busy,done,error} got=%b want=%b", $time, act, exp);
            end
            if (m_done_edge) begin
                exp_chain = '0;
                for (int i = 0; i < CHAIN_LEN; i++)
                    if (i < acc.size()) exp_chain[CHAIN_LEN-1-i] = acc[i];
                last_chain = tb_chain;
                checks++;
                if (tb_chain !== exp_chain || acc.size() < CHAIN_LEN) begin
                    errors++;
                    $display("FAIL chain_content got=%h want=%h", tb_chain, exp_chain);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_src();
        cfg_valid = (src.size() > 0) && ($urandom_range(99) < gate_pct);
        cfg_data  = (src.size() > 0) ? src[0] : DATA_W'($urandom);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
        start = 0;
        abort = 0;
        drive_src();
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) src.push_back(DATA_W'($urandom));
        drive_src();
    endtask

    // ticks until the DUT reports done or error; returns the number of edges taken
    task automatic wait_end(input string nm, output int n);
        n = 0;
        while (!(done || error) && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout got=no_end want=done_or_error", nm);
        end
    endtask

    int n;

    initial begin
        prog_reset = 1; start = 0; abort = 0; cfg_valid = 0; cfg_data = '0;
        repeat (3) @(posedge prog_clk);
        #1;
        chk_en = 1;
        chk("reset_outputs", {ccff_head, cfg_ready, busy, done, error}, 5'b0);
        prog_reset = 0;
        tick();

        // nominal load: A5 3C FF 00 C0 back-to-back
        src = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'hC0};
        drive_src();
        pulse_start();
        wait_end("nominal", n);
        chk("nominal_latency", n, 36);
        chk("nominal_done", done, 1);
        chk("nominal_error", error, 0);
        tick();
        chk("nominal_chain", last_chain, 34'h294F3FC03);
        repeat (3) tick();
        chk("nominal_done_sticky", {done, ccff_head, cfg_ready}, 3'b100);
        src.delete();

        // underrun: only two words ever arrive
        src = '{8'h12, 8'h34};
        drive_src();
        pulse_start();
        wait_end("underrun", n);
        chk("underrun_latency", n, 18);
        chk("underrun_flags", {error, done, ccff_head, busy}, 4'b1000);
        repeat (2) tick();
        chk("underrun_sticky", error, 1);

        // abort after bit 10
        push_rand(5);
        pulse_start();
        repeat (11) tick();
        chk("abort_busy_before", busy, 1);
        abort = 1;
        tick();
        chk("abort_state", {busy, done, ccff_head, cfg_ready}, 4'b0000);
        src.delete();
        drive_src();
        push_rand(5);
        pulse_start();
        wait_end("after_abort", n);
        chk("after_abort_latency", n, 36);
        chk("after_abort_done", {done, error}, 2'b10);
        src.delete();

        // reset mid-load after bit 20
        push_rand(5);
        pulse_start();
        repeat (21) tick();
        prog_reset = 1;
        tick();
        chk("midreset_outputs", {ccff_head, cfg_ready, busy, done, error}, 5'b0);
        prog_reset = 0;
        src.delete();
        drive_src();
        tick();
        push_rand(5);
        pulse_start();
        wait_end("after_reset", n);
        chk("after_reset_latency", n, 36);
        src.delete();

        // reload from DONE with stray start pulses during SHIFT
        chk("reload_from_done", done, 1);
        push_rand(5);
        pulse_start();
        chk("reload_done_clears", {done, busy}, 2'b01);
        n = 0;
        while (!(done || error) && n < 200) begin
            if (n == 10 || n == 20) start = 1;
            tick();
            n++;
        end
        chk("reload_latency", n, 36);
        chk("reload_done", {done, error}, 2'b10);
        src.delete();

        // randomized loads: gaps, short streams, occasional aborts
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2))
                0: gate_pct = 100;
                1: gate_pct = 85;
                default: gate_pct = 60;
            endcase
            push_rand(($urandom_range(4) == 0) ? $urandom_range(1, 4) : 5);
            pulse_start();
            n = 0;
            while ((m_mode == M_FILL || m_mode == M_SHIFT) && n < 400) begin
                if ($urandom_range(99) == 0) abort = 1;
                tick();
                n++;
            end
            if (n >= 400) begin
                errors++;
                $display("FAIL random_timeout iter=%0d got=busy want=ended", it);
            end
            src.delete();
            drive_src();
            repeat ($urandom_range(1, 3)) tick();
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_stream_loader.md
CCFF_STREAM_LOADER -- requirements
Module: ccff_stream_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of each configuration word accepted from the bitstream source.
REQ-002 Parameter CHAIN_LEN, default 34: number of bits in the downstream ccff chain; CHAIN_LEN >= 1.
REQ-003 prog_clk  input  1  programming clock; the block and the downstream chain both sample on its rising edge.
REQ-004 prog_reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 abort  input  1  single-cycle request to terminate any load in progress.
REQ-007 cfg_data  input  DATA_W  configuration word; bit DATA_W-1 is shifted out first.
REQ-008 cfg_valid  input  1  cfg_data is valid.
REQ-009 cfg_ready  output  1  block accepts cfg_data on this edge when cfg_valid is also high.
REQ-010 ccff_head  output  1  registered serial data driving the head of the configuration chain.
REQ-011 busy  output  1  high in FILL and SHIFT.
REQ-012 done  output  1  sticky; a full chain has been loaded.
REQ-013 error  output  1  sticky; the stream underran mid-load.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, FILL, SHIFT, DONE and ERR.
REQ-015 IDLE: ccff_head=0, cfg_ready=0; start -> FILL, clearing done, error, bit counter and holding register.
REQ-016 FILL: cfg_ready=1, ccff_head=0; a handshake loads the shift register with cfg_data, sets the word bit counter to DATA_W and moves to SHIFT. Zeros shifted into the chain during FILL are permitted, since only the final CHAIN_LEN bits configure the chain.
REQ-017 SHIFT: on every edge, ccff_head <= shift register MSB, the shift register shifts left, the word bit counter decrements and bit_cnt increments; there is no stall cycle.
REQ-018 SHIFT SHALL provide a one-word holding register; cfg_ready = NOT hold_valid, and a handshake fills the holding register.
REQ-019 When the last bit of the current word is driven and hold_valid=1, the next edge SHALL load the shift register from the holding register and clear hold_valid, with no gap on ccff_head. A handshake on that same edge SHALL refill the holding register.
REQ-020 When the last bit of the current word is driven, hold_valid=0 and bit_cnt < CHAIN_LEN, the FSM SHALL go to ERR on the next edge. Underrun is an error because the chain shifts every prog_clk edge.
REQ-021 When bit_cnt reaches CHAIN_LEN, the FSM SHALL enter DONE on the edge after the CHAIN_LEN-th bit is presented.
REQ-022 On entering DONE, ccff_head SHALL return to 0, unused bits of the current word and any held word SHALL be discarded, and cfg_ready=0.
REQ-023 DONE: done=1, ccff_head=0, cfg_ready=0; start -> FILL, clearing done.
REQ-024 ERR: error=1, ccff_head=0, cfg_ready=0; start -> FILL, clearing error.
REQ-025 abort in any state SHALL go to IDLE on the next edge, drive ccff_head=0 and leave done=0. abort takes priority over start and over any handshake on the same edge.
REQ-026 start in FILL or SHIFT SHALL be ignored.
REQ-027 bit_cnt SHALL be clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-028 The word bit counter SHALL be clog2(DATA_W+1) bits wide.
REQ-029 When CHAIN_LEN is not a multiple of DATA_W, the final word SHALL supply only its upper (CHAIN_LEN mod DATA_W) bits.

Reset
REQ-030 prog_reset SHALL force IDLE on the next edge and take priority over all other inputs.
REQ-031 Reset values: ccff_head=0, cfg_ready=0, busy=0, done=0, error=0, hold_valid=0, bit_cnt=0, shift register=0.
REQ-032 Reset asserted mid-SHIFT SHALL take effect on the next edge, with ccff_head=0 from that edge on.

Verification
REQ-033 Nominal: start, then 5 words A5,3C,FF,00,C0 supplied back-to-back with cfg_valid held high -> 34 contiguous bits on ccff_head MSB-first, equal to A5 3C FF 00 followed by bits 1,1. done=1 on the edge after bit 34 and stays high; error=0.
REQ-034 Underrun: cfg_valid drops after the second word -> after the 16th bit, ERR is entered on the next edge; error=1, ccff_head=0, done=0.
REQ-035 Backpressure: in SHIFT with hold_valid=1, cfg_valid is held high -> cfg_ready=0 until the word boundary; no word is lost or duplicated (compare against a scoreboard).
REQ-036 Abort: abort after bit 10 -> IDLE on the next edge; busy=0, done=0, ccff_head=0. A subsequent start reloads correctly.
REQ-037 Reset mid-load after bit 20 -> all outputs at their reset values on the next edge. A subsequent start performs a full correct load.
REQ-038 Reload: start while in DONE -> done clears the next cycle and a second 34-bit load completes. start pulses during SHIFT have no effect.
